// File: rtl/register_bank.sv
// 16 x 32-bit register file: one synchronous write port, two combinational read ports.
// The BYPASS parameter chooses between write-through reads and old-value reads on an address collision.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] dest,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic [ADDR_WIDTH-1:0] srcadd1,
    input  logic [ADDR_WIDTH-1:0] srcadd2,
    output logic [DATA_WIDTH-1:0] src1,
    output logic [DATA_WIDTH-1:0] src2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [DEPTH];
    logic                  w_wr_live;
    logic                  w_hit1;
    logic                  w_hit2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we) begin
            r_regs[dest] <= Din;
        end
    end

    // A write held off by reset must not leak through the bypass path either.
    assign w_wr_live = we && rst_n && (BYPASS != 0);
    assign w_hit1    = w_wr_live && (srcadd1 == dest);
    assign w_hit2    = w_wr_live && (srcadd2 == dest);

    always_comb begin
        src1 = r_regs[srcadd1];
        src2 = r_regs[srcadd2];
        if (!rst_n) begin
            src1 = '0;
            src2 = '0;
        end else begin
            if (w_hit1) begin
                src1 = Din;
            end
            if (w_hit2) begin
                src2 = Din;
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: a BYPASS=1 and a BYPASS=0 instance share all inputs.
module tb_register_bank;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  dest;
    logic [31:0] Din;
    logic [3:0]  srcadd1;
    logic [3:0]  srcadd2;
    logic [31:0] b_src1, b_src2;
    logic [31:0] n_src1, n_src2;

    int checks   = 0;
    int failures = 0;

    register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .dest(dest), .Din(Din),
        .srcadd1(srcadd1), .srcadd2(srcadd2), .src1(b_src1), .src2(b_src2)
    );

    register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(0)) u_nob (
        .clk(clk), .rst_n(rst_n), .we(we), .dest(dest), .Din(Din),
        .srcadd1(srcadd1), .srcadd2(srcadd2), .src1(n_src1), .src2(n_src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all4(input string tag, input logic [31:0] e1, input logic [31:0] e2);
        check({tag, "_b1"}, b_src1, e1);
        check({tag, "_b2"}, b_src2, e2);
        check({tag, "_n1"}, n_src1, e1);
        check({tag, "_n2"}, n_src2, e2);
    endtask

    initial begin
        rst_n = 1'b1; we = 1'b0; dest = '0; Din = '0; srcadd1 = '0; srcadd2 = '0;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            srcadd1 = 4'(i); srcadd2 = 4'(15 - i);
            #1;
            check_all4($sformatf("rst_init_%0d", i), 32'h0, 32'h0);
        end

        // Writes during reset are ignored, and not bypassed either.
        we = 1'b1; dest = 4'd2; Din = 32'h1111_2222; srcadd1 = 4'd2; srcadd2 = 4'd2;
        #1;
        check_all4("rst_wr_comb", 32'h0, 32'h0);
        step();
        step();
        we = 1'b0;
        #1;
        check_all4("rst_wr_held", 32'h0, 32'h0);

        // Release reset between edges, then load every register.
        #2 rst_n = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            we = 1'b1; dest = 4'(i); Din = 32'hA5A5_0000 + 32'(i);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            srcadd1 = 4'(i); srcadd2 = 4'(15 - i);
            #1;
            check_all4($sformatf("sweep_%0d", i), 32'hA5A5_0000 + 32'(i), 32'hA5A5_000F - 32'(i));
        end

        // Write enable low holds register 3.
        we = 1'b1; dest = 4'd3; Din = 32'h1234_5678;
        step();
        we = 1'b0; Din = 32'hDEAD_BEEF; srcadd1 = 4'd3; srcadd2 = 4'd4;
        for (int c = 0; c < 3; c++) begin
            step();
            check_all4($sformatf("we0_hold_%0d", c), 32'h1234_5678, 32'hA5A5_0004);
        end

        // Collision on register 7: bypass vs. stored value before the edge.
        we = 1'b1; dest = 4'd7; Din = 32'hCAFE_F00D; srcadd1 = 4'd7; srcadd2 = 4'd7;
        #1;
        check("coll_b1", b_src1, 32'hCAFE_F00D);
        check("coll_b2", b_src2, 32'hCAFE_F00D);
        check("coll_n1", n_src1, 32'hA5A5_0007);
        check("coll_n2", n_src2, 32'hA5A5_0007);
        srcadd2 = 4'd6;
        #1;
        check("coll_indep_b1", b_src1, 32'hCAFE_F00D);
        check("coll_indep_b2", b_src2, 32'hA5A5_0006);
        step();
        we = 1'b0; srcadd2 = 4'd7;
        #1;
        check_all4("coll_after", 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Back-to-back writes to one address: last one wins.
        we = 1'b1; dest = 4'd9; Din = 32'h0000_0001;
        step();
        Din = 32'h0000_0002;
        step();
        we = 1'b0; srcadd1 = 4'd9; srcadd2 = 4'd9;
        #1;
        check_all4("b2b", 32'h0000_0002, 32'h0000_0002);

        // Boundary values in registers 0 and 15.
        we = 1'b1; dest = 4'd0; Din = 32'hFFFF_FFFF;
        step();
        dest = 4'd15; Din = 32'h8000_0001;
        step();
        we = 1'b0; srcadd1 = 4'd0; srcadd2 = 4'd15;
        #1;
        check_all4("bound_a", 32'hFFFF_FFFF, 32'h8000_0001);
        srcadd1 = 4'd15; srcadd2 = 4'd0;
        #1;
        check_all4("bound_b", 32'h8000_0001, 32'hFFFF_FFFF);

        // Reset asserted between edges while writes stream.
        we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dest = 4'(i + 10); Din = 32'h5000_0000 + 32'(i);
            step();
        end
        dest = 4'd12; Din = 32'h7777_7777;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            srcadd1 = 4'(i); srcadd2 = 4'(i);
            #1;
            check_all4($sformatf("midrst_%0d", i), 32'h0, 32'h0);
        end
        step();
        #2 rst_n = 1'b1; we = 1'b0;
        step();
        we = 1'b1; dest = 4'd5; Din = 32'h0000_0055;
        step();
        we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            srcadd1 = 4'(i); srcadd2 = 4'(15 - i);
            #1;
            check_all4($sformatf("post_rst_%0d", i),
                       (i == 5) ? 32'h0000_0055 : 32'h0,
                       (15 - i == 5) ? 32'h0000_0055 : 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
